// File: rtl/fir_shared_adder_sched.sv
// Time-multiplexed 5-tap shift-and-add FIR controller: one external adder is
// reused across all taps, one tap per cycle, with valid/ready on both sides.
module fir_shared_adder_sched #(
  parameter int WIDTH   = 16,
  parameter int TAPS    = 5,
  parameter int SHIFT_W = 3,
  parameter logic [TAPS*SHIFT_W-1:0] SHIFTS = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dataout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  output logic             busy,
  output logic [2:0]       tap_idx
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [2:0] LAST_TAP = 3'(TAPS - 1);

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [2:0]       tap_q;
  logic [WIDTH-1:0] d_q [TAPS];

  logic [WIDTH-1:0]   term [TAPS];
  logic [SHIFT_W-1:0] shift_amt [TAPS];

  // Pre-shift every tap so the shared adder only needs a mux on operand B.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_term
    assign shift_amt[gi] = SHIFTS[gi*SHIFT_W +: SHIFT_W];
    assign term[gi]      = d_q[gi] >> shift_amt[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      tap_q   <= '0;
      for (int k = 0; k < TAPS; k++) d_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_q[0] <= x;
            for (int k = 1; k < TAPS; k++) d_q[k] <= d_q[k-1];
            acc_q   <= '0;
            tap_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= add_sum;
          if (tap_q == LAST_TAP) begin
            tap_q   <= '0;
            state_q <= DONE;
          end else begin
            tap_q <= tap_q + 3'd1;
          end
        end
        DONE: begin
          // Result holds in acc_q until the consumer takes it.
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dataout   = acc_q;
  assign tap_idx   = tap_q;
  assign add_a     = (state_q == ACCUM) ? acc_q : '0;
  assign add_b     = (state_q == ACCUM) ? term[tap_q] : '0;
  assign add_cin   = 1'b0;

endmodule
